load_store_unit: RTL

- Memory stage of the RV32I core.
- Executes LOAD/STORE ops decoded with the LOAD_STORE_FNS funct3 encoding (BYTE, HALF, WORD, BYTE_U, HALF_U) against a req/gnt/rvalid data-memory port.
- Aligns byte lanes, sign- or zero-extends load data, detects misalignment, and owns the memory-mapped output port register at OUTPORT_ADDR.
- Its response feeds the FROM_MEM leg of the regfile write-data mux.

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared load/store encodings, outport address and LSU state type
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    localparam logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC;
    localparam logic [29:0] OUTPORT_WORD = OUTPORT_ADDR[31:2];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication, load extraction/extension and fault check
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        fault
);

    logic [31:0] shifted;

    always_comb begin
        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = 32'h0;
        fault    = 1'b0;
        shifted  = raw >> {lane, 3'b000};
        case (funct3)
            BYTE, BYTE_U: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = (funct3 == BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'h0, shifted[7:0]};
            end
            HALF, HALF_U: begin
                be       = 4'b0011 << lane;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = (funct3 == HALF) ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'h0, shifted[15:0]};
                fault    = lane[0];
            end
            WORD: begin
                be    = 4'b1111;
                rdata = raw;
                fault = (lane != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: req/gnt/rvalid data port sequencing plus the outport register
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] OUTPORT_RST = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       outport
);

    lsu_state_t  state, state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [2:0]  al_funct3;
    logic [1:0]  al_lane;
    logic [31:0] al_raw;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_fault;
    logic        accept;
    logic        fault;
    logic        is_out;

    // One aligner serves both the accept cycle (live request, outport as read source)
    // and the WAIT cycle (latched funct3/lane, memory word as read source).
    assign al_funct3 = (state == IDLE) ? req_funct3    : funct3_q;
    assign al_lane   = (state == IDLE) ? req_addr[1:0] : lane_q;
    assign al_raw    = (state == IDLE) ? outport       : mem_rdata;

    lsu_align u_align (
        .funct3   (al_funct3),
        .lane     (al_lane),
        .wdata    (req_wdata),
        .raw      (al_raw),
        .be       (al_be),
        .wdata_sh (al_wdata),
        .rdata    (al_rdata),
        .fault    (al_fault)
    );

    assign accept = req_valid && req_ready;
    assign fault  = al_fault || (req_is_store && (req_funct3 == BYTE_U || req_funct3 == HALF_U));
    assign is_out = (req_addr[ADDR_W-1:2] == OUTPORT_WORD[ADDR_W-3:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (fault || is_out) ? RESP : REQ;
            REQ:     if (mem_gnt) state_nxt = mem_we ? RESP : WAIT;
            WAIT:    if (mem_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            REQ:     mem_req   = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Response fields only change on the edge that enters RESP so they hold in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q       <= 3'b000;
            lane_q         <= 2'b00;
            mem_we         <= 1'b0;
            mem_be         <= 4'b0000;
            mem_addr       <= '0;
            mem_wdata      <= 32'h0;
            rsp_rdata      <= 32'h0;
            rsp_misaligned <= 1'b0;
            outport        <= OUTPORT_RST;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    funct3_q  <= req_funct3;
                    lane_q    <= req_addr[1:0];
                    mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_we    <= req_is_store;
                    mem_be    <= al_be;
                    mem_wdata <= al_wdata;
                    if (fault) begin
                        rsp_rdata      <= 32'h0;
                        rsp_misaligned <= 1'b1;
                    end else if (is_out) begin
                        rsp_misaligned <= 1'b0;
                        rsp_rdata      <= req_is_store ? 32'h0 : al_rdata;
                        if (req_is_store) begin
                            for (int i = 0; i < 4; i++) begin
                                if (al_be[i]) outport[8*i +: 8] <= al_wdata[8*i +: 8];
                            end
                        end
                    end
                end
                REQ: if (mem_gnt && mem_we) begin
                    rsp_rdata      <= 32'h0;
                    rsp_misaligned <= 1'b0;
                end
                WAIT: if (mem_rvalid) begin
                    rsp_rdata      <= al_rdata;
                    rsp_misaligned <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
